// File: rtl/instmem_port_arbiter_pkg.sv
// Shared widths, flow-control codes and arbiter state encodings for the
// instruction-memory port arbiter.
package instmem_port_arbiter_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int FLOW_WIDTH = 2;

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

  localparam int ARB_ST_WIDTH = 2;

  localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_IDLE      = 2'd0;
  localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_WAIT_IF   = 2'd1;
  localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_WAIT_MEM  = 2'd2;
  localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_WAIT_DROP = 2'd3;

  typedef enum logic [ARB_ST_WIDTH-1:0] {
    ST_IDLE      = ARB_ST_IDLE,
    ST_WAIT_IF   = ARB_ST_WAIT_IF,
    ST_WAIT_MEM  = ARB_ST_WAIT_MEM,
    ST_WAIT_DROP = ARB_ST_WAIT_DROP
  } arb_state_e;

endpackage

// File: rtl/instmem_port_arbiter.sv
// Shares the single-port instruction memory between IF fetches and MEM-stage
// data reads, one outstanding transaction at a time, and drives the stall codes.
//
// state        | meaning
// ST_IDLE      | no transaction outstanding; arbitrate and issue im_req_o
// ST_WAIT_IF   | fetch granted, waiting for its read data
// ST_WAIT_MEM  | data read granted, waiting for its read data
// ST_WAIT_DROP | fetch flushed after grant; swallow its response silently
module instmem_port_arbiter
  import instmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [CPU_WIDTH-1:0]  if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [CPU_WIDTH-1:0]  if_rdata_o,
  input  logic                  mem_req_i,
  input  logic [CPU_WIDTH-1:0]  mem_addr_i,
  output logic                  mem_rvalid_o,
  output logic [CPU_WIDTH-1:0]  mem_rdata_o,
  input  logic                  flush_i,
  output logic [FLOW_WIDTH-1:0] flow_if_o,
  output logic [FLOW_WIDTH-1:0] flow_mem_o,
  output logic                  im_req_o,
  output logic [CPU_WIDTH-1:0]  im_addr_o,
  input  logic                  im_gnt_i,
  input  logic                  im_rvalid_i,
  input  logic [CPU_WIDTH-1:0]  im_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] LP_LIMIT     = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic                 LP_STARVE_EN = (STARVE_LIMIT != 0);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  logic w_if_act;
  logic w_starved;
  logic w_fetch_own;
  logic w_req;
  logic w_gnt;
  logic w_rsp_if;
  logic w_rsp_mem;

  assign w_if_act    = if_req_i & ~flush_i;
  assign w_starved   = LP_STARVE_EN & (r_cnt == LP_LIMIT);
  assign w_fetch_own = w_if_act & (~mem_req_i | w_starved);
  // Gated by rst so every request-side output sits at its idle value in reset.
  assign w_req       = ~rst & (r_state == ST_IDLE) & (mem_req_i | w_if_act);
  assign w_gnt       = w_req & im_gnt_i;

  // A response landing in the same cycle as a flush belongs to a discarded fetch.
  assign w_rsp_if  = (r_state == ST_WAIT_IF) & im_rvalid_i & ~flush_i;
  assign w_rsp_mem = (r_state == ST_WAIT_MEM) & im_rvalid_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = w_fetch_own ? ST_WAIT_IF : ST_WAIT_MEM;
        end
      end
      ST_WAIT_IF: begin
        if (im_rvalid_i) begin
          w_state_nxt = ST_IDLE;
        end else if (flush_i) begin
          w_state_nxt = ST_WAIT_DROP;
        end
      end
      ST_WAIT_MEM: begin
        if (im_rvalid_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DROP: begin
        if (im_rvalid_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!if_req_i) begin
      w_cnt_nxt = '0;
    end else if (w_gnt && w_fetch_own) begin
      w_cnt_nxt = '0;
    end else if (w_gnt && (r_cnt != LP_LIMIT)) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign im_req_o  = w_req;
  assign im_addr_o = w_req ? (w_fetch_own ? if_addr_i : mem_addr_i) : '0;
  assign if_gnt_o  = w_gnt & w_fetch_own;

  assign if_rvalid_o  = w_rsp_if;
  assign if_rdata_o   = w_rsp_if ? im_rdata_i : '0;
  assign mem_rvalid_o = w_rsp_mem;
  assign mem_rdata_o  = w_rsp_mem ? im_rdata_i : '0;

  always_comb begin
    flow_mem_o = FLOW_WORK;
    if (rst || (mem_req_i && !w_rsp_mem)) begin
      flow_mem_o = FLOW_STOP;
    end
  end

  always_comb begin
    flow_if_o = FLOW_WORK;
    if (rst) begin
      flow_if_o = FLOW_STOP;
    end else if (flush_i) begin
      flow_if_o = FLOW_REFRESH;
    end else if (if_req_i && !w_rsp_if) begin
      flow_if_o = FLOW_STOP;
    end
  end

endmodule
